serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, minimum 2.
- REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-004 SHALL have port start, input, 1: request to begin one subtraction.
- REQ-005 SHALL have port a, input, WIDTH: minuend, sampled on the accepted start.
- REQ-006 SHALL have port b, input, WIDTH: subtrahend, sampled on the accepted start.
- REQ-007 SHALL have port busy, output, 1: high while a subtraction is in progress.
- REQ-008 SHALL have port dout, output, 1: serial difference bit, LSB first.
- REQ-009 SHALL have port dout_valid, output, 1: dout is meaningful this cycle.
- REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
- REQ-011 SHALL have port diff, output, WIDTH: parallel result (a-b) mod 2^WIDTH, held until the next accepted start.
- REQ-012 SHALL have port borrow_out, output, 1: final borrow, where 1 means a<b unsigned; held with diff.

Function
- REQ-013 SHALL implement the states IDLE, RUN and DONE.
- REQ-014 SHALL accept start only in IDLE.
  - Accepting start latches a and b, clears the borrow flop and the bit counter, and moves to RUN.
  - start in RUN or DONE SHALL be ignored.
- REQ-015 SHALL process one bit per cycle in RUN, LSB first, using the bit index held in the counter.
  - Difference bit: d = a_i ^ b_i ^ brw.
  - Next borrow: brw' = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
- REQ-016 SHALL drive dout=d and dout_valid=1 in every RUN cycle.
  - d is also shifted into diff, MSB-inserting, so that diff is correct on completion.
- REQ-017 SHALL leave RUN for DONE after exactly WIDTH RUN cycles.
- REQ-018 SHALL drive done=1 and busy=0 for exactly one cycle in DONE, then return to IDLE.
  - done SHALL rise WIDTH+1 cycles after the cycle in which start was sampled.
- REQ-019 SHALL drive busy=1 exactly in RUN.
- REQ-020 SHALL allow a new start in the IDLE cycle immediately following DONE; back-to-back throughput is one result per WIDTH+2 cycles.
- REQ-021 SHALL keep a and b changes after acceptance from affecting the result in progress.
- REQ-022 SHALL keep the bit counter in the range 0..WIDTH-1 with no wrap visible on outputs.

Reset
- REQ-023 SHALL, when rst is high at a clock edge, force IDLE and the following output values, regardless of state or start.
  - busy=0, done=0, dout=0, dout_valid=0.
  - diff=0, borrow_out=0 (and ovf=0 when present).
- REQ-024 SHALL abort any subtraction in progress on reset, with no done pulse.
- REQ-025 SHALL give rst priority over start when both are high.

Configuration
- REQ-026 SHALL, when SERIAL_SUB_OVF_EN is defined, add output port ovf, 1 bit.
  - ovf is the two's-complement signed overflow of a-b, computed as a[MSB]^b[MSB] & a[MSB]^diff[MSB].
  - ovf is valid from done onward and held with diff.
- REQ-027 SHALL, when SERIAL_SUB_OVF_EN is undefined, have no ovf port and no overflow logic.

Structure
- REQ-028 SHALL take the state enumeration type and the default WIDTH constant from shared package serial_sub_pkg.
- REQ-029 SHALL instantiate one combinational sub-module, sub_cell: a 1-bit full subtractor (inputs a, b, bin; outputs d, bout) used per RUN cycle.

Verification
- REQ-030 SHALL cover WIDTH=8, a=0x05, b=0x03, one start pulse:
  - dout sequence 0,1,0,0,0,0,0,0 with dout_valid high 8 cycles.
  - done 9 cycles after start; diff=0x02, borrow_out=0.
- REQ-031 SHALL cover a=0x00, b=0x01:
  - diff=0xFF, borrow_out=1, ovf=0.
- REQ-032 SHALL cover SERIAL_SUB_OVF_EN, with both operand pairs:
  - a=0x80, b=0x01: diff=0x7F, borrow_out=0, ovf=1.
  - a=0x7F, b=0xFF: diff=0x80, borrow_out=1, ovf=1.
- REQ-033 SHALL cover start held high continuously with a=0x10, b=0x01:
  - Results 0x0F every 10 cycles; no start accepted while busy.
- REQ-034 SHALL cover rst asserted on the 4th RUN cycle:
  - Next cycle all outputs are 0, state is IDLE, and no done pulse occurs.
  - A subsequent start with a=0x09, b=0x09 gives diff=0x00, borrow_out=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state type and default operand width for serial_sub
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/serial_sub_sub_cell.sv
// sub_cell: 1-bit full subtractor (in: a, b, bin; out: d difference, bout borrow)
module sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a-b, LSB first (in: clk, rst, start, a, b; out: busy, dout, dout_valid, done, diff, borrow_out, ovf when SERIAL_SUB_OVF_EN)
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  logic brw, d, bout, last, accept;
  assign last = cnt == CW'(WIDTH - 1);
  assign accept = state == IDLE && start;
  sub_cell u_cell (
    .a(a_q[cnt]),
    .b(b_q[cnt]),
    .bin(brw),
    .d(d),
    .bout(bout)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    busy = state == RUN;
    dout_valid = state == RUN;
    dout = state == RUN && d;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      brw <= 1'b0;
      diff <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      cnt <= '0;
      brw <= 1'b0;
    end else if (busy) begin
      diff <= {d, diff[WIDTH-1:1]};
      brw <= bout;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end
  assign borrow_out = brw;
`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (busy && last) ovf <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d);
  end
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized and directed self-checking bench for serial_sub against an arithmetic reference
module tb_serial_sub;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] a = 0, b = 0, diff;
  logic busy, dout, dout_valid, done, borrow_out, ovf_w;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  serial_sub #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .dout(dout),
    .dout_valid(dout_valid),
    .done(done),
    .diff(diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf(ovf_w)
`endif
  );
`ifndef SERIAL_SUB_OVF_EN
  assign ovf_w = 1'b0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_sub(input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] exp_d;
    int sd;
    exp_d = 8'((int'(av) - int'(bv)) & 255);
    sd = int'($signed(av)) - int'($signed(bv));
    @(negedge clk);
    start = 1;
    a = av;
    b = bv;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("busy", busy, 1);
      check("dout_valid", dout_valid, 1);
      check("dout", dout, exp_d[i]);
      check("done_early", done, 0);
      start = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
    end
    start = 0;
    check("done", done, 1);
    check("busy_in_done", busy, 0);
    check("dv_in_done", dout_valid, 0);
    check("diff", diff, exp_d);
    check("borrow", borrow_out, av < bv);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", ovf_w, sd > 127 || sd < -128);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("diff_held", diff, exp_d);
    check("borrow_held", borrow_out, av < bv);
  endtask
  initial begin
    int last_done;
    start = 1;
    a = 8'hAA;
    b = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_ovf", ovf_w, 0);
    start = 0;
    rst = 0;
    do_sub(8'h05, 8'h03);
    do_sub(8'h00, 8'h01);
    do_sub(8'h80, 8'h01);
    do_sub(8'h7F, 8'hFF);
    do_sub(8'h00, 8'h00);
    do_sub(8'hFF, 8'hFF);
    for (int k = 0; k < 25; k++) do_sub(8'($urandom), 8'($urandom));
    @(negedge clk);
    start = 1;
    a = 8'h10;
    b = 8'h01;
    last_done = 0;
    for (int n = 1; n < 40; n++) begin
      @(negedge clk);
      check("b2b_done", done, (n % 10) == 9);
      check("b2b_busy", busy, (n % 10) >= 1 && (n % 10) <= 8);
      if (done) begin
        check("b2b_diff", diff, 8'h0F);
        check("b2b_borrow", borrow_out, 0);
        if (last_done > 0) check("b2b_gap", n - last_done, 10);
        last_done = n;
      end
    end
    start = 0;
    repeat (12) @(negedge clk);
    start = 1;
    a = 8'h5A;
    b = 8'h3C;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dout", dout, 0);
    check("abort_dv", dout_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow_out, 0);
    check("abort_ovf", ovf_w, 0);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_idle", busy, 0);
    end
    do_sub(8'h09, 8'h09);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
